genreg_bridge: RTL

Executes single read/write transactions on the on-board generic register bus on behalf of the Master FPGA. It sits directly downstream of the register block:
- it consumes the generic address/control word (R5) and write data (R6);
- it returns read data that the register block presents as R7.

It converts a software-level "GO" bit into a bus request/acknowledge handshake, with timeout protection and sticky status.

---
 rtl/genreg_bridge.sv | 81 ++++++++
 1 files changed

// File: rtl/genreg_bridge.sv
// genreg_bridge: turns a software GO edge into one generic-bus request/ack
// transaction with timeout protection and sticky done/timeout/overrun status.
module genreg_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] genreg_addr_ctrl,
    input  logic [31:0] genreg_wr_data,
    output logic [31:0] genreg_rd_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        genreg_busy,
    output logic        genreg_done,
    output logic        genreg_timeout,
    output logic        genreg_overrun
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    state_t      state;
    logic        go_d;
    logic [15:0] count;
    logic        start;
    assign start = genreg_addr_ctrl[31] & ~go_d;
    assign genreg_busy = state != IDLE;
    // go_d resets high so a GO level held across reset cannot launch a transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            go_d           <= 1'b1;
            count          <= '0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            genreg_rd_data <= '0;
            genreg_done    <= 1'b0;
            genreg_timeout <= 1'b0;
            genreg_overrun <= 1'b0;
        end else begin
            go_d <= genreg_addr_ctrl[31];
            case (state)
                IDLE: if (start) begin
                    bus_addr       <= genreg_addr_ctrl[15:0];
                    bus_we         <= ~genreg_addr_ctrl[30];
                    bus_wdata      <= genreg_wr_data;
                    genreg_done    <= 1'b0;
                    genreg_timeout <= 1'b0;
                    genreg_overrun <= 1'b0;
                    count          <= '0;
                    bus_req        <= 1'b1;
                    state          <= REQ;
                end
                REQ: begin
                    count <= count + 16'd1;
                    if (start) genreg_overrun <= 1'b1;
                    if (bus_ack) begin
                        if (!bus_we) genreg_rd_data <= bus_rdata;
                        genreg_done <= 1'b1;
                        bus_req     <= 1'b0;
                        state       <= DONE;
                    end else if (count == LAST) begin
                        if (!bus_we) genreg_rd_data <= ERR_DATA;
                        genreg_timeout <= 1'b1;
                        bus_req        <= 1'b0;
                        state          <= DONE;
                    end
                end
                default: begin
                    if (start) genreg_overrun <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
